pic_cmd_regfile: RTL and testbench
==================================

// Module: pic_cmd_regfile
// PURPOSE
//  Command register bank for the 8259 PIC. Sits directly downstream of the read/write decode logic.
//  Latches decoded ICW1-4 / OCW1-3 writes and runs the initialisation sequence.
//  Exports mode/mask fields to priority resolver and cascade logic; serves CPU read-back (IRR/ISR/IMR).
// PARAMETERS
//  RST_IMR     8'h00  IMR value after reset and after every ICW1
//  RST_RD_ISR  1'b0   read-register select after reset/ICW1 (0=IRR, 1=ISR)
// PORTS
//  clk         in   1  system clock; single clock domain
//  rst         in   1  synchronous, active-high reset
//  wr_stb      in   1  one-cycle pulse: decoded write valid
//  cmd_type    in   1  1=ICW, 0=OCW (qualified by wr_stb)
//  cmd_nr      in   2  ICW: 0..3 = ICW1..4; OCW: 0=OCW1, 1=OCW2, 2=OCW3
//  cmd_data    in   8  write data byte
//  rd_stb      in   1  one-cycle pulse: CPU read request
//  rd_a0       in   1  A0 sampled with rd_stb
//  irr_in      in   8  interrupt request register from IRR block
//  isr_in      in   8  in-service register from ISR block
//  rd_data     out  8  read-back byte
//  rd_valid    out  1  one-cycle pulse, rd_data valid
//  init_done   out  1  1 = initialisation complete
//  imr         out  8  interrupt mask (OCW1)
//  vec_base    out  5  ICW2[7:3]
//  ltim        out  1  ICW1[3]; sngl out 1 = ICW1[1]
//  cas_cfg     out  8  ICW3 byte
//  icw4_bits   out  5  ICW4[4:0] {SFNM,BUF,M/S,AEOI,uPM}
//  ocw2_stb    out  1  one-cycle pulse, OCW2 issued
//  ocw2_cmd    out  3  OCW2[7:5] {R,SL,EOI}, held until next OCW2
//  ocw2_lvl    out  3  OCW2[2:0], held until next OCW2
//  smm         out  1  special mask mode
//  seq_err     out  1  one-cycle pulse, write rejected
// BEHAVIOUR
//  Reset: all outputs 0 except imr=RST_IMR; read select = RST_RD_ISR; FSM=UNINIT.
//  FSM states: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
//  Writes act on the clock edge where wr_stb=1; outputs update the next cycle.
//  ICW1 in any state:
//   - latches ltim, sngl, ic4; imr<=RST_IMR; smm<=0; icw4_bits<=0; read select reset
//   - init_done<=0; -> WAIT_ICW2.
//  ICW2 in WAIT_ICW2: vec_base<=d[7:3]. Next: sngl=0 -> WAIT_ICW3; else ic4 -> WAIT_ICW4; else READY.
//  ICW3 in WAIT_ICW3: cas_cfg<=d. Next: ic4 -> WAIT_ICW4, else READY.
//  ICW4 in WAIT_ICW4: icw4_bits<=d[4:0] -> READY.
//  Entering READY sets init_done=1.
//  Any ICW with unexpected nr for current state: no register change, state held, seq_err pulses.
//  OCW in READY:
//   - OCW1: imr<=d.
//   - OCW2: ocw2_cmd/ocw2_lvl latched, ocw2_stb pulses 1 cycle.
//   - OCW3: RR=1 -> read select<=RIS; ESMM=1 -> smm<=SMM; bits with enable=0 leave state unchanged.
//  OCW in any state other than READY: ignored, seq_err pulses.
//  Reads:
//   - rd_stb sampled at edge N; rd_data/rd_valid valid at N+1 (latency 1).
//   - rd_a0=1 -> imr; rd_a0=0 -> isr_in or irr_in per read select.
//   - rd_data holds its value until the next read.
//  Simultaneous wr_stb and rd_stb: read returns pre-write contents; write takes effect normally.
//  rst overrides everything, including a mid-sequence init.
// CONFIGURATION
//  PIC_POLL_EN defined:
//   - OCW3 with P=1 (d[2]) sets poll_pend.
//   - Next read (either A0) returns {|irr_m,4'b0,lvl}: irr_m = irr_in & ~imr, lvl = lowest set index.
//   - That read clears poll_pend; OCW3 P has priority over RR.
//  PIC_POLL_EN undefined: P bit ignored, no poll logic.
// STRUCTURE
//  Shared package pic_pkg: FSM state encoding; CMD_ICW/CMD_OCW; nr codes (ICW1..4, OCW1..3);
//  OCW3 bit indices (RIS=0, RR=1, P=2, SMM=5, ESMM=6); ICW4 field indices.
//  Natural sub-module: pic_rdback_mux (read-select register, poll priority encoder, registered output).
// TESTING
//  T1 ICW1=8'h13 (sngl, ic4), ICW2=8'h20, ICW4=8'h01
//     -> vec_base=5'h04, icw4_bits=5'h01, init_done=1 after ICW4, no seq_err.
//  T2 ICW1=8'h11, ICW2, ICW3=8'h04, ICW4=8'h1D
//     -> cas_cfg=8'h04, icw4_bits=5'h1D, FSM passes through WAIT_ICW3.
//  T3 READY, OCW1=8'hA5, read A0=1 -> rd_data=8'hA5 one cycle later
//     -> new ICW1 restores imr=RST_IMR and clears init_done.
//  T4 OCW3=8'h0B, irr_in=8'h12, isr_in=8'h80, read A0=0 -> 8'h80
//     -> OCW3=8'h0A, same read -> 8'h12.
//  T5 OCW1 in WAIT_ICW2, or ICW3 in READY -> seq_err pulse, registers unchanged
//     -> OCW2=8'h63 -> ocw2_stb 1 cycle, ocw2_cmd=3'b011, ocw2_lvl=3'd3.
//  T6 (PIC_POLL_EN) imr=8'h01, irr_in=8'h05, OCW3=8'h0C, read -> 8'h82
//     -> second read returns IRR/ISR per read select.

Source files
------------

// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the 8259 PIC command register bank:
//   - initialisation FSM state encoding
//   - command type / command number codes as produced by the write decoder
//   - ICW1, ICW4 and OCW3 bit positions
//   - lowest-set-bit helper used by the poll response
// ---------------------------------------------------------------------------
package pic_pkg;

    typedef enum logic [2:0] {
        ST_UNINIT    = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } pic_state_t;

    localparam logic CMD_ICW = 1'b1;
    localparam logic CMD_OCW = 1'b0;

    localparam logic [1:0] NR_ICW1 = 2'd0;
    localparam logic [1:0] NR_ICW2 = 2'd1;
    localparam logic [1:0] NR_ICW3 = 2'd2;
    localparam logic [1:0] NR_ICW4 = 2'd3;

    localparam logic [1:0] NR_OCW1 = 2'd0;
    localparam logic [1:0] NR_OCW2 = 2'd1;
    localparam logic [1:0] NR_OCW3 = 2'd2;

    // ICW1 bit positions
    localparam int unsigned ICW1_IC4  = 0;
    localparam int unsigned ICW1_SNGL = 1;
    localparam int unsigned ICW1_LTIM = 3;

    // ICW4 field positions (icw4_bits = {SFNM,BUF,M/S,AEOI,uPM})
    localparam int unsigned ICW4_UPM  = 0;
    localparam int unsigned ICW4_AEOI = 1;
    localparam int unsigned ICW4_MS   = 2;
    localparam int unsigned ICW4_BUF  = 3;
    localparam int unsigned ICW4_SFNM = 4;

    // OCW3 bit positions
    localparam int unsigned OCW3_RIS  = 0;
    localparam int unsigned OCW3_RR   = 1;
    localparam int unsigned OCW3_P    = 2;
    localparam int unsigned OCW3_SMM  = 5;
    localparam int unsigned OCW3_ESMM = 6;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [2:0] pic_lowest_set(input logic [7:0] v);
        logic [2:0] lvl;
        lvl = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[7 - i]) lvl = 3'(7 - i);
        end
        return lvl;
    endfunction

endpackage

// File: rtl/pic_rdback_mux.sv
// ---------------------------------------------------------------------------
// pic_rdback_mux
// CPU read-back path: holds the IRR/ISR read-select register, optionally the
// poll-pending flag and poll encoder, and registers the read-back byte.
// Optional feature macro: PIC_POLL_EN (poll command support).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_icw1         ICW1 accepted: restore read select (and drop poll)
//   i_ocw3_wr      OCW3 accepted
//   i_ocw3_ris     OCW3 RIS bit
//   i_ocw3_rr      OCW3 RR bit (enables RIS)
//   i_ocw3_p       OCW3 P bit (poll request)
//   i_rd_stb       CPU read request
//   i_rd_a0        A0 of the read
//   i_imr/i_irr/i_isr  sources for the read-back byte
//   o_rd_data      read-back byte, held until next read
//   o_rd_valid     one-cycle pulse with each read
// ---------------------------------------------------------------------------
module pic_rdback_mux
    import pic_pkg::*;
#(
    parameter logic RST_RD_ISR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_icw1,
    input  logic       i_ocw3_wr,
    input  logic       i_ocw3_ris,
    input  logic       i_ocw3_rr,
    input  logic       i_ocw3_p,
    input  logic       i_rd_stb,
    input  logic       i_rd_a0,
    input  logic [7:0] i_imr,
    input  logic [7:0] i_irr,
    input  logic [7:0] i_isr,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid
);

    logic       r_rd_isr;
    logic [7:0] r_rd_data;
    logic       r_rd_valid;
    logic [7:0] w_rd_sel;

`ifdef PIC_POLL_EN
    logic       r_poll_pend;
    logic [7:0] w_irr_m;

    assign w_irr_m = i_irr & ~i_imr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_poll_pend <= 1'b0;
        end else if (i_icw1) begin
            r_poll_pend <= 1'b0;
        end else if (i_ocw3_wr && i_ocw3_p) begin
            // a new poll request wins over a read consuming the old one
            r_poll_pend <= 1'b1;
        end else if (i_rd_stb) begin
            r_poll_pend <= 1'b0;
        end
    end

    always_comb begin
        w_rd_sel = '0;
        if (r_poll_pend)
            w_rd_sel = {|w_irr_m, 4'b0000, pic_lowest_set(w_irr_m)};
        else if (i_rd_a0)
            w_rd_sel = i_imr;
        else if (r_rd_isr)
            w_rd_sel = i_isr;
        else
            w_rd_sel = i_irr;
    end
`else
    logic w_unused_poll;
    assign w_unused_poll = i_ocw3_p;

    always_comb begin
        w_rd_sel = '0;
        if (i_rd_a0)
            w_rd_sel = i_imr;
        else if (r_rd_isr)
            w_rd_sel = i_isr;
        else
            w_rd_sel = i_irr;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_isr   <= RST_RD_ISR;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_stb;
            if (i_rd_stb)
                r_rd_data <= w_rd_sel;
            if (i_icw1)
                r_rd_isr <= RST_RD_ISR;
            else if (i_ocw3_wr && i_ocw3_rr)
                r_rd_isr <= i_ocw3_ris;
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/pic_cmd_regfile.sv
// ---------------------------------------------------------------------------
// pic_cmd_regfile
// 8259 PIC command register bank. Latches decoded ICW1-4 / OCW1-3 writes,
// runs the initialisation sequence and serves CPU read-back.
// Optional feature macro: PIC_POLL_EN (OCW3 poll command).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_stb            decoded write valid (1 cycle)
//   cmd_type          1=ICW, 0=OCW
//   cmd_nr            ICW1..4 = 0..3, OCW1..3 = 0..2
//   cmd_data          write data
//   rd_stb, rd_a0     CPU read request and its A0
//   irr_in, isr_in    IRR / ISR contents for read-back
//   rd_data, rd_valid read-back byte (latency 1) and valid pulse
//   init_done         initialisation complete
//   imr               interrupt mask
//   vec_base          ICW2[7:3]
//   ltim, sngl        ICW1[3], ICW1[1]
//   cas_cfg           ICW3 byte
//   icw4_bits         ICW4[4:0]
//   ocw2_stb          OCW2 issued pulse; ocw2_cmd/ocw2_lvl held fields
//   smm               special mask mode
//   seq_err           write rejected pulse
// ---------------------------------------------------------------------------
module pic_cmd_regfile
    import pic_pkg::*;
#(
    parameter logic [7:0] RST_IMR    = 8'h00,
    parameter logic       RST_RD_ISR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_stb,
    input  logic       cmd_type,
    input  logic [1:0] cmd_nr,
    input  logic [7:0] cmd_data,
    input  logic       rd_stb,
    input  logic       rd_a0,
    input  logic [7:0] irr_in,
    input  logic [7:0] isr_in,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       init_done,
    output logic [7:0] imr,
    output logic [4:0] vec_base,
    output logic       ltim,
    output logic       sngl,
    output logic [7:0] cas_cfg,
    output logic [4:0] icw4_bits,
    output logic       ocw2_stb,
    output logic [2:0] ocw2_cmd,
    output logic [2:0] ocw2_lvl,
    output logic       smm,
    output logic       seq_err
);

    pic_state_t r_state, w_state_nxt;

    logic       r_ic4;
    logic       r_ltim;
    logic       r_sngl;
    logic [7:0] r_imr;
    logic [4:0] r_vec_base;
    logic [7:0] r_cas_cfg;
    logic [4:0] r_icw4_bits;
    logic       r_ocw2_stb;
    logic [2:0] r_ocw2_cmd;
    logic [2:0] r_ocw2_lvl;
    logic       r_smm;
    logic       r_seq_err;

    logic w_icw, w_ocw, w_ready;
    logic w_icw1, w_icw2, w_icw3, w_icw4;
    logic w_ocw1, w_ocw2, w_ocw3;
    logic w_reject;

    always_comb begin
        w_icw   = wr_stb && (cmd_type == CMD_ICW);
        w_ocw   = wr_stb && (cmd_type == CMD_OCW);
        w_ready = (r_state == ST_READY);

        w_icw1 = w_icw && (cmd_nr == NR_ICW1);
        w_icw2 = w_icw && (cmd_nr == NR_ICW2) && (r_state == ST_WAIT_ICW2);
        w_icw3 = w_icw && (cmd_nr == NR_ICW3) && (r_state == ST_WAIT_ICW3);
        w_icw4 = w_icw && (cmd_nr == NR_ICW4) && (r_state == ST_WAIT_ICW4);

        w_ocw1 = w_ocw && w_ready && (cmd_nr == NR_OCW1);
        w_ocw2 = w_ocw && w_ready && (cmd_nr == NR_OCW2);
        w_ocw3 = w_ocw && w_ready && (cmd_nr == NR_OCW3);

        w_reject = (w_icw && !(w_icw1 || w_icw2 || w_icw3 || w_icw4)) ||
                   (w_ocw && !(w_ocw1 || w_ocw2 || w_ocw3));
    end

    // Initialisation FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (w_icw1) begin
            w_state_nxt = ST_WAIT_ICW2;
        end else if (w_icw2) begin
            if (!r_sngl)
                w_state_nxt = ST_WAIT_ICW3;
            else if (r_ic4)
                w_state_nxt = ST_WAIT_ICW4;
            else
                w_state_nxt = ST_READY;
        end else if (w_icw3) begin
            w_state_nxt = r_ic4 ? ST_WAIT_ICW4 : ST_READY;
        end else if (w_icw4) begin
            w_state_nxt = ST_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_UNINIT;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ic4       <= 1'b0;
            r_ltim      <= 1'b0;
            r_sngl      <= 1'b0;
            r_imr       <= RST_IMR;
            r_vec_base  <= '0;
            r_cas_cfg   <= '0;
            r_icw4_bits <= '0;
            r_ocw2_stb  <= 1'b0;
            r_ocw2_cmd  <= '0;
            r_ocw2_lvl  <= '0;
            r_smm       <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_ocw2_stb <= w_ocw2;
            r_seq_err  <= w_reject;
            if (w_icw1) begin
                r_ic4       <= cmd_data[ICW1_IC4];
                r_sngl      <= cmd_data[ICW1_SNGL];
                r_ltim      <= cmd_data[ICW1_LTIM];
                r_imr       <= RST_IMR;
                r_smm       <= 1'b0;
                r_icw4_bits <= '0;
            end
            if (w_icw2) r_vec_base  <= cmd_data[7:3];
            if (w_icw3) r_cas_cfg   <= cmd_data;
            if (w_icw4) r_icw4_bits <= cmd_data[ICW4_SFNM:ICW4_UPM];
            if (w_ocw1) r_imr       <= cmd_data;
            if (w_ocw2) begin
                r_ocw2_cmd <= cmd_data[7:5];
                r_ocw2_lvl <= cmd_data[2:0];
            end
            if (w_ocw3 && cmd_data[OCW3_ESMM])
                r_smm <= cmd_data[OCW3_SMM];
        end
    end

    pic_rdback_mux #(
        .RST_RD_ISR (RST_RD_ISR)
    ) u_rdback (
        .clk        (clk),
        .rst        (rst),
        .i_icw1     (w_icw1),
        .i_ocw3_wr  (w_ocw3),
        .i_ocw3_ris (cmd_data[OCW3_RIS]),
        .i_ocw3_rr  (cmd_data[OCW3_RR]),
        .i_ocw3_p   (cmd_data[OCW3_P]),
        .i_rd_stb   (rd_stb),
        .i_rd_a0    (rd_a0),
        .i_imr      (r_imr),
        .i_irr      (irr_in),
        .i_isr      (isr_in),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid)
    );

    assign init_done = w_ready;
    assign imr       = r_imr;
    assign vec_base  = r_vec_base;
    assign ltim      = r_ltim;
    assign sngl      = r_sngl;
    assign cas_cfg   = r_cas_cfg;
    assign icw4_bits = r_icw4_bits;
    assign ocw2_stb  = r_ocw2_stb;
    assign ocw2_cmd  = r_ocw2_cmd;
    assign ocw2_lvl  = r_ocw2_lvl;
    assign smm       = r_smm;
    assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_pic_cmd_regfile.sv
// ---------------------------------------------------------------------------
// tb_pic_cmd_regfile
// Self-checking bench for pic_cmd_regfile: a transaction-level model of the
// register bank is compared against every output on every falling edge, and
// directed scenarios carry hand-computed literal expectations.
// Optional feature macro: PIC_POLL_EN (enables poll scenario and model).
// ---------------------------------------------------------------------------
module tb_pic_cmd_regfile;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_stb = 1'b0;
    logic       cmd_type = 1'b0;
    logic [1:0] cmd_nr = '0;
    logic [7:0] cmd_data = '0;
    logic       rd_stb = 1'b0;
    logic       rd_a0 = 1'b0;
    logic [7:0] irr_in = '0;
    logic [7:0] isr_in = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       init_done;
    logic [7:0] imr;
    logic [4:0] vec_base;
    logic       ltim;
    logic       sngl;
    logic [7:0] cas_cfg;
    logic [4:0] icw4_bits;
    logic       ocw2_stb;
    logic [2:0] ocw2_cmd;
    logic [2:0] ocw2_lvl;
    logic       smm;
    logic       seq_err;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    pic_cmd_regfile #(
        .RST_IMR    (8'h00),
        .RST_RD_ISR (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_stb    (wr_stb),
        .cmd_type  (cmd_type),
        .cmd_nr    (cmd_nr),
        .cmd_data  (cmd_data),
        .rd_stb    (rd_stb),
        .rd_a0     (rd_a0),
        .irr_in    (irr_in),
        .isr_in    (isr_in),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .init_done (init_done),
        .imr       (imr),
        .vec_base  (vec_base),
        .ltim      (ltim),
        .sngl      (sngl),
        .cas_cfg   (cas_cfg),
        .icw4_bits (icw4_bits),
        .ocw2_stb  (ocw2_stb),
        .ocw2_cmd  (ocw2_cmd),
        .ocw2_lvl  (ocw2_lvl),
        .smm       (smm),
        .seq_err   (seq_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // m_expect: which ICW number the sequence will accept next
    // (0 = never initialised, 2..4 = ICWn, 5 = initialised).
    int         m_expect;
    logic       m_ic4, m_sngl, m_ltim, m_smm, m_rd_isr, m_poll;
    logic [7:0] m_imr, m_cas, m_rd_data;
    logic [4:0] m_vec, m_icw4;
    logic [2:0] m_o2cmd, m_o2lvl;
    logic       m_o2stb, m_seq_err, m_rd_valid;

    function automatic logic [7:0] poll_byte(input logic [7:0] irr, input logic [7:0] msk);
        logic [7:0] req;
        int lvl;
        req = irr & ~msk;
        lvl = 0;
        for (int k = 7; k >= 0; k--) if (req[k]) lvl = k;
        return (req != 0) ? (8'h80 | 8'(lvl)) : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_expect = 0; m_ic4 = 0; m_sngl = 0; m_ltim = 0; m_smm = 0;
            m_rd_isr = 0; m_poll = 0; m_imr = 8'h00; m_cas = 0; m_rd_data = 0;
            m_vec = 0; m_icw4 = 0; m_o2cmd = 0; m_o2lvl = 0;
            m_o2stb = 0; m_seq_err = 0; m_rd_valid = 0;
        end else begin
            m_o2stb    = 0;
            m_seq_err  = 0;
            m_rd_valid = rd_stb;
            // read sees the contents before any simultaneous write
            if (rd_stb) begin
                if (m_poll) m_rd_data = poll_byte(irr_in, m_imr);
                else if (rd_a0) m_rd_data = m_imr;
                else m_rd_data = m_rd_isr ? isr_in : irr_in;
                m_poll = 0;
            end
            if (wr_stb && cmd_type) begin
                int n;
                n = int'(cmd_nr) + 1;
                if (n == 1) begin
                    m_ic4 = cmd_data[0]; m_sngl = cmd_data[1]; m_ltim = cmd_data[3];
                    m_imr = 8'h00; m_smm = 0; m_icw4 = 0; m_rd_isr = 0; m_poll = 0;
                    m_expect = 2;
                end else if (n == m_expect) begin
                    if (n == 2) m_vec = cmd_data[7:3];
                    if (n == 3) m_cas = cmd_data;
                    if (n == 4) m_icw4 = cmd_data[4:0];
                    // skip ICW3 in single mode, ICW4 when not requested
                    if (n == 2 && !m_sngl) m_expect = 3;
                    else if (n < 4 && m_ic4) m_expect = 4;
                    else m_expect = 5;
                end else begin
                    m_seq_err = 1;
                end
            end else if (wr_stb) begin
                if (m_expect != 5 || cmd_nr == 2'd3) m_seq_err = 1;
                else if (cmd_nr == 2'd0) m_imr = cmd_data;
                else if (cmd_nr == 2'd1) begin
                    m_o2stb = 1; m_o2cmd = cmd_data[7:5]; m_o2lvl = cmd_data[2:0];
                end else begin
                    if (cmd_data[1]) m_rd_isr = cmd_data[0];
                    if (cmd_data[6]) m_smm = cmd_data[5];
`ifdef PIC_POLL_EN
                    if (cmd_data[2]) m_poll = 1;
`endif
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("init_done", 32'(init_done), 32'(m_expect == 5));
            chk("imr",       32'(imr),       32'(m_imr));
            chk("vec_base",  32'(vec_base),  32'(m_vec));
            chk("ltim",      32'(ltim),      32'(m_ltim));
            chk("sngl",      32'(sngl),      32'(m_sngl));
            chk("cas_cfg",   32'(cas_cfg),   32'(m_cas));
            chk("icw4_bits", 32'(icw4_bits), 32'(m_icw4));
            chk("ocw2_stb",  32'(ocw2_stb),  32'(m_o2stb));
            chk("ocw2_cmd",  32'(ocw2_cmd),  32'(m_o2cmd));
            chk("ocw2_lvl",  32'(ocw2_lvl),  32'(m_o2lvl));
            chk("smm",       32'(smm),       32'(m_smm));
            chk("seq_err",   32'(seq_err),   32'(m_seq_err));
            chk("rd_valid",  32'(rd_valid),  32'(m_rd_valid));
            chk("rd_data",   32'(rd_data),   32'(m_rd_data));
        end
    end

    // ---------------- stimulus ----------------
    // Each task starts and ends 1 time unit after a rising edge.
    task automatic wr(input logic t, input logic [1:0] nr, input logic [7:0] d);
        wr_stb = 1'b1; cmd_type = t; cmd_nr = nr; cmd_data = d;
        @(posedge clk); #1;
        wr_stb = 1'b0; cmd_data = '0;
    endtask

    task automatic rd(input logic a0);
        rd_stb = 1'b1; rd_a0 = a0;
        @(posedge clk); #1;
        rd_stb = 1'b0; rd_a0 = 1'b0;
    endtask

    task automatic wr_rd(input logic t, input logic [1:0] nr, input logic [7:0] d, input logic a0);
        wr_stb = 1'b1; cmd_type = t; cmd_nr = nr; cmd_data = d;
        rd_stb = 1'b1; rd_a0 = a0;
        @(posedge clk); #1;
        wr_stb = 1'b0; cmd_data = '0; rd_stb = 1'b0; rd_a0 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        // reset state
        chk("rst_imr",       32'(imr),       32'h00);
        chk("rst_init_done", 32'(init_done), 32'h0);
        chk("rst_rd_valid",  32'(rd_valid),  32'h0);
        chk("rst_rd_data",   32'(rd_data),   32'h00);
        chk("rst_seq_err",   32'(seq_err),   32'h0);
        chk_en = 1'b1;

        // T1: single, ICW4
        wr(1'b1, 2'd0, 8'h13);
        wr(1'b1, 2'd1, 8'h20);
        chk("t1_mid_init_done", 32'(init_done), 32'h0);
        wr(1'b1, 2'd3, 8'h01);
        chk("t1_vec_base",  32'(vec_base),  32'h04);
        chk("t1_icw4_bits", 32'(icw4_bits), 32'h01);
        chk("t1_init_done", 32'(init_done), 32'h1);
        chk("t1_seq_err",   32'(seq_err),   32'h0);

        // T2: cascade mode, passes through WAIT_ICW3 (ICW4 early is rejected)
        wr(1'b1, 2'd0, 8'h11);
        chk("t2_icw1_init_done", 32'(init_done), 32'h0);
        wr(1'b1, 2'd1, 8'h08);
        wr(1'b1, 2'd3, 8'h1D);
        chk("t2_early_icw4_err", 32'(seq_err),   32'h1);
        chk("t2_early_icw4_reg", 32'(icw4_bits), 32'h00);
        wr(1'b1, 2'd2, 8'h04);
        chk("t2_wait4_init_done", 32'(init_done), 32'h0);
        wr(1'b1, 2'd3, 8'h1D);
        chk("t2_cas_cfg",   32'(cas_cfg),   32'h04);
        chk("t2_icw4_bits", 32'(icw4_bits), 32'h1D);
        chk("t2_vec_base",  32'(vec_base),  32'h01);
        chk("t2_init_done", 32'(init_done), 32'h1);

        // T3: mask write / read-back, re-init restores IMR
        wr(1'b0, 2'd0, 8'hA5);
        rd(1'b1);
        chk("t3_rd_imr",   32'(rd_data),  32'hA5);
        chk("t3_rd_valid", 32'(rd_valid), 32'h1);
        idle(2);
        chk("t3_rd_hold",  32'(rd_data),  32'hA5);
        chk("t3_rd_valid_low", 32'(rd_valid), 32'h0);
        wr(1'b1, 2'd0, 8'h13);
        chk("t3_reinit_imr",  32'(imr),       32'h00);
        chk("t3_reinit_done", 32'(init_done), 32'h0);
        wr(1'b1, 2'd1, 8'h20);
        wr(1'b1, 2'd3, 8'h01);

        // T4: read select via OCW3
        irr_in = 8'h12; isr_in = 8'h80;
        wr(1'b0, 2'd2, 8'h0B);
        rd(1'b0);
        chk("t4_rd_isr", 32'(rd_data), 32'h80);
        wr(1'b0, 2'd2, 8'h0A);
        rd(1'b0);
        chk("t4_rd_irr", 32'(rd_data), 32'h12);

        // T5: sequence errors, OCW2 pulse
        wr(1'b1, 2'd0, 8'h13);
        wr(1'b0, 2'd0, 8'hFF);
        chk("t5_ocw_err",  32'(seq_err), 32'h1);
        chk("t5_ocw_imr",  32'(imr),     32'h00);
        wr(1'b1, 2'd1, 8'h20);
        wr(1'b1, 2'd3, 8'h01);
        wr(1'b1, 2'd2, 8'h55);
        chk("t5_icw3_err", 32'(seq_err), 32'h1);
        chk("t5_icw3_cas", 32'(cas_cfg), 32'h04);
        chk("t5_icw3_rdy", 32'(init_done), 32'h1);
        wr(1'b0, 2'd1, 8'h63);
        chk("t5_ocw2_stb", 32'(ocw2_stb), 32'h1);
        chk("t5_ocw2_cmd", 32'(ocw2_cmd), 32'h3);
        chk("t5_ocw2_lvl", 32'(ocw2_lvl), 32'h3);
        idle(1);
        chk("t5_ocw2_stb_low", 32'(ocw2_stb), 32'h0);
        chk("t5_ocw2_hold",    32'(ocw2_cmd), 32'h3);

        // special mask mode: ESMM gates SMM
        wr(1'b0, 2'd2, 8'h68);
        chk("smm_set",  32'(smm), 32'h1);
        wr(1'b0, 2'd2, 8'h28);
        chk("smm_keep", 32'(smm), 32'h1);
        wr(1'b0, 2'd2, 8'h48);
        chk("smm_clr",  32'(smm), 32'h0);

        // simultaneous write and read: read returns pre-write IMR
        wr(1'b0, 2'd0, 8'h5A);
        wr_rd(1'b0, 2'd0, 8'h3C, 1'b1);
        chk("wr_rd_old", 32'(rd_data), 32'h5A);
        chk("wr_rd_new", 32'(imr),     32'h3C);

`ifdef PIC_POLL_EN
        // T6: poll returns lowest unmasked request, then normal read resumes
        wr(1'b0, 2'd0, 8'h01);
        irr_in = 8'h05;
        wr(1'b0, 2'd2, 8'h0C);
        rd(1'b0);
        chk("t6_poll",   32'(rd_data), 32'h82);
        rd(1'b0);
        chk("t6_after",  32'(rd_data), 32'h05);
        wr(1'b0, 2'd0, 8'hFF);
        wr(1'b0, 2'd2, 8'h0C);
        rd(1'b1);
        chk("t6_poll_none", 32'(rd_data), 32'h00);
`else
        // P bit ignored: read follows A0 / read select
        wr(1'b0, 2'd0, 8'h01);
        irr_in = 8'h05;
        wr(1'b0, 2'd2, 8'h0C);
        rd(1'b0);
        chk("nopoll_rd", 32'(rd_data), 32'h05);
`endif

        // reset mid-sequence
        wr(1'b1, 2'd0, 8'h11);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_imr",  32'(imr),      32'h00);
        chk("mid_rst_vec",  32'(vec_base), 32'h00);
        chk("mid_rst_done", 32'(init_done), 32'h0);
        wr(1'b1, 2'd1, 8'h20);
        chk("mid_rst_icw2_err", 32'(seq_err), 32'h1);
        idle(3);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
